wb_stage_p: RTL and testbench
=============================

Name: wb_stage_p

Overview:
Parametrised writeback stage for the pipelined datapath, successor to the fixed 32-bit ALU/memory writeback mux. It selects the writeback source (ALU, load data, link PC), sign/zero-extends sub-word loads, and registers the result with a valid/ready handshake toward the register-file write port. It also provides an optional skid entry, flush, zero-register write suppression, a forwarding tap and a retired-write counter. It sits between the MEM/WB pipeline register and the register file.

Parameters:
DATA_W, 32, datapath width; multiple of 16, 32 or 64 supported
REG_ADDR_W, 5, register index width
SKID, 1, 1 = two-entry buffer with registered In_Ready; 0 = single entry with combinational In_Ready
ZERO_REG, 1, 1 = writes to register 0 are suppressed
CNT_W, 16, width of the retired-write counter

Ports:
Clk  in  1  clock; all state updates on rising edge
Rst_n  in  1  asynchronous active-low reset
In_Valid  in  1  upstream holds a valid writeback transaction
In_Ready  out  1  stage accepts; transfer when In_Valid&&In_Ready
Alu_In  in  DATA_W  ALU result
Mem_In  in  DATA_W  raw memory read word
Pc4_In  in  DATA_W  link address
WBSel_In  in  2  0=ALU, 1=load, 2=link, 3=ALU (reserved)
RegWrite_In  in  1  transaction writes the register file
Dst_In  in  REG_ADDR_W  destination register
MemSize_In  in  2  0=byte, 1=half, 2=32-bit word, 3=full DATA_W
MemSigned_In  in  1  1 = sign-extend load, 0 = zero-extend
ByteOff_In  in  log2(DATA_W/8)  byte address offset of load
Flush  in  1  discard all held transactions
Out_Ready  in  1  register-file port can take a write this cycle
Out_Valid  out  1  output entry holds a transaction
Data_Out  out  DATA_W  writeback data
Dst_Out  out  REG_ADDR_W  writeback destination
RegWrite_Out  out  1  commit writes the register file
Fwd_Valid  out  1  Out_Valid&&RegWrite_Out
Fwd_Dst  out  REG_ADDR_W  equals Dst_Out
Fwd_Data  out  DATA_W  equals Data_Out
Commit_Cnt  out  CNT_W  number of retired writes

Behaviour:
- Reset (async, Rst_n=0): Out_Valid=0, skid valid=0, Data_Out=0, Dst_Out=0, RegWrite_Out=0, Commit_Cnt=0. In_Ready=1 when SKID=1; In_Ready=Out_Ready-independent 1 when SKID=0 (output empty).
- Data is formatted combinationally at the input and captured on acceptance. Latency is 1 cycle from accept to Out_Valid when the output entry is free.
- Load extension, little-endian: byte lane = ByteOff. Half lane = ByteOff[msb:1]; ByteOff[0] is ignored on a misaligned half. 32-bit lane = ByteOff[msb:2] (DATA_W=64 only). Size 3 passes Mem_In unchanged. MemSigned selects the fill bit (lane msb or 0). Size 3 with DATA_W=32 is treated as size 2.
- ZERO_REG=1 and Dst_In=0: captured RegWrite=0. The transaction still flows and still counts as a transfer.
- Output transfer occurs when Out_Valid&&Out_Ready.
- Commit_Cnt increments by 1 on a transfer with RegWrite_Out=1 and wraps modulo 2^CNT_W.
- SKID=0: In_Ready = !Out_Valid || Out_Ready. On accept the output loads; on transfer without accept Out_Valid clears.
- SKID=1: In_Ready = !skid_valid (registered).
  - Accept while the output is stalled (Out_Valid && !Out_Ready): write the skid entry.
  - On transfer with skid full: the skid moves to the output and skid_valid clears.
  - Accept and transfer in the same cycle with skid empty: the input goes to the output.
  - Order is always preserved. The skid is never written while full.
- Flush: on the next edge Out_Valid=0 and skid_valid=0. Any same-cycle accept is discarded. Flush has priority over all other updates. A same-cycle transfer still counts (the consumer saw it).
- Out_Ready may be low indefinitely. Outputs hold stable while Out_Valid && !Out_Ready.
- Reset mid-transaction drops all contents immediately.

Decomposition:
- Shared package: WBSel encodings (WB_ALU, WB_MEM, WB_PC4), MemSize encodings (SZ_B, SZ_H, SZ_W, SZ_D).
- Sub-module load_ext_p: combinational lane select and extension, parametrised on DATA_W. Instantiated once.

Test Plan:
- Mem_In=32'h80FF_7F01, WBSel=1, size=byte, signed, ByteOff=2 -> Data_Out=32'hFFFF_FFFF. Same with ByteOff=3, unsigned -> 32'h0000_0080.
- Half load, Mem_In=32'h8001_1234, ByteOff=2, signed -> 32'hFFFF_8001. ByteOff=3 gives the same result (bit0 ignored).
- SKID=1: three back-to-back transactions with Out_Ready=0 for 2 cycles. In_Ready drops after 2 accepts, the third waits. After release, outputs appear in order with no loss or duplication.
- Dst_In=0, RegWrite_In=1, Alu_In=32'h1234 -> Out_Valid=1, RegWrite_Out=0, Commit_Cnt unchanged.
- Flush asserted with output and skid full and In_Valid=1 -> next cycle Out_Valid=0, In_Ready=1, nothing retired.
- CNT_W=4: 17 writing transfers -> Commit_Cnt=1. Rst_n pulsed asynchronously mid-stall -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/wb_stage_p_pkg.sv
// Shared encodings for the writeback stage.
//   wb_sel_e     : writeback source select (ALU result, formatted load, link PC)
//   mem_size_e   : load access size (byte, half, 32-bit word, full datapath word)
package wb_stage_p_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_RSV = 2'd3   // reserved, behaves as WB_ALU
    } wb_sel_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_e;

endpackage

// File: rtl/wb_stage_p_load_ext.sv
// Load lane select and sign/zero extension (purely combinational).
//   mem       : raw memory read word
//   size      : access size (mem_size_e encoding)
//   signed_ld : 1 = fill with lane msb, 0 = fill with zeros
//   byte_off  : little-endian byte offset of the access
//   data      : extended load value
module load_ext_p
    import wb_stage_p_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]           mem,
    input  logic [1:0]                  size,
    input  logic                        signed_ld,
    input  logic [$clog2(DATA_W/8)-1:0] byte_off,
    output logic [DATA_W-1:0]           data
);

    localparam int OFF_W = $clog2(DATA_W/8);

    // Offset masks: a half ignores offset bit 0, a 32-bit word ignores bits 1:0.
    localparam logic [OFF_W-1:0] OFFM_H = ~OFF_W'(1);
    localparam logic [OFF_W-1:0] OFFM_W = ~OFF_W'(3);

    localparam logic [DATA_W-1:0] MASK_B = DATA_W'(8'hFF);
    localparam logic [DATA_W-1:0] MASK_H = DATA_W'(16'hFFFF);
    // On a 32-bit (or narrower) datapath the word mask covers everything,
    // so a word load degenerates to a pass-through.
    localparam logic [DATA_W-1:0] MASK_W = DATA_W'(32'hFFFF_FFFF);
    localparam int WMSB = (DATA_W > 32) ? 31 : DATA_W - 1;

    logic [DATA_W-1:0] shift_b;
    logic [DATA_W-1:0] shift_h;
    logic [DATA_W-1:0] shift_w;
    logic              fill;

    always_comb begin
        shift_b = mem >> {byte_off, 3'b000};
        shift_h = mem >> {byte_off & OFFM_H, 3'b000};
        shift_w = mem >> {byte_off & OFFM_W, 3'b000};
        fill    = 1'b0;
        data    = mem;
        case (mem_size_e'(size))
            SZ_B: begin
                fill = signed_ld & shift_b[7];
                data = (shift_b & MASK_B) | (fill ? ~MASK_B : '0);
            end
            SZ_H: begin
                fill = signed_ld & shift_h[15];
                data = (shift_h & MASK_H) | (fill ? ~MASK_H : '0);
            end
            SZ_W: begin
                fill = signed_ld & shift_w[WMSB];
                data = (shift_w & MASK_W) | (fill ? ~MASK_W : '0);
            end
            default: data = mem;  // full-width load passes through
        endcase
    end

endmodule

// File: rtl/wb_stage_p.sv
// Writeback stage between the MEM/WB pipeline register and the register file.
// Formats the writeback value (ALU / extended load / link PC) at the input,
// captures it on acceptance and presents it with a valid/ready handshake.
//   Clk, Rst_n        : clock, asynchronous active-low reset
//   In_Valid/In_Ready : upstream handshake
//   Alu_In, Mem_In, Pc4_In, WBSel_In, RegWrite_In, Dst_In,
//   MemSize_In, MemSigned_In, ByteOff_In : incoming transaction fields
//   Flush             : drop every held transaction on the next edge
//   Out_Valid/Out_Ready : register-file write handshake
//   Data_Out, Dst_Out, RegWrite_Out : committed write
//   Fwd_Valid, Fwd_Dst, Fwd_Data    : forwarding tap of the output entry
//   Commit_Cnt        : retired register writes, wraps
module wb_stage_p
    import wb_stage_p_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int SKID       = 1,
    parameter int ZERO_REG   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                        Clk,
    input  logic                        Rst_n,
    input  logic                        In_Valid,
    output logic                        In_Ready,
    input  logic [DATA_W-1:0]           Alu_In,
    input  logic [DATA_W-1:0]           Mem_In,
    input  logic [DATA_W-1:0]           Pc4_In,
    input  logic [1:0]                  WBSel_In,
    input  logic                        RegWrite_In,
    input  logic [REG_ADDR_W-1:0]       Dst_In,
    input  logic [1:0]                  MemSize_In,
    input  logic                        MemSigned_In,
    input  logic [$clog2(DATA_W/8)-1:0] ByteOff_In,
    input  logic                        Flush,
    input  logic                        Out_Ready,
    output logic                        Out_Valid,
    output logic [DATA_W-1:0]           Data_Out,
    output logic [REG_ADDR_W-1:0]       Dst_Out,
    output logic                        RegWrite_Out,
    output logic                        Fwd_Valid,
    output logic [REG_ADDR_W-1:0]       Fwd_Dst,
    output logic [DATA_W-1:0]           Fwd_Data,
    output logic [CNT_W-1:0]            Commit_Cnt
);

    logic [DATA_W-1:0]     load_data;
    logic [DATA_W-1:0]     in_data;
    logic                  in_rw;

    logic                  out_valid_reg, out_valid_next;
    logic [DATA_W-1:0]     out_data_reg,  out_data_next;
    logic [REG_ADDR_W-1:0] out_dst_reg,   out_dst_next;
    logic                  out_rw_reg,    out_rw_next;

    logic                  skid_valid_reg, skid_valid_next;
    logic [DATA_W-1:0]     skid_data_reg,  skid_data_next;
    logic [REG_ADDR_W-1:0] skid_dst_reg,   skid_dst_next;
    logic                  skid_rw_reg,    skid_rw_next;

    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  accept;
    logic                  xfer;

    load_ext_p #(.DATA_W(DATA_W)) u_load_ext (
        .mem       (Mem_In),
        .size      (MemSize_In),
        .signed_ld (MemSigned_In),
        .byte_off  (ByteOff_In),
        .data      (load_data)
    );

    // Input formatting: source select and zero-register suppression.
    always_comb begin
        case (wb_sel_e'(WBSel_In))
            WB_MEM:  in_data = load_data;
            WB_PC4:  in_data = Pc4_In;
            default: in_data = Alu_In;
        endcase
        in_rw = RegWrite_In && !((ZERO_REG != 0) && (Dst_In == '0));
    end

    // With the skid entry In_Ready comes straight from a flop, breaking the
    // combinational ready path back from the register file.
    assign In_Ready = (SKID != 0) ? !skid_valid_reg : (!out_valid_reg || Out_Ready);
    assign accept   = In_Valid && In_Ready;
    assign xfer     = out_valid_reg && Out_Ready;

    always_comb begin
        out_valid_next  = out_valid_reg;
        out_data_next   = out_data_reg;
        out_dst_next    = out_dst_reg;
        out_rw_next     = out_rw_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_dst_next   = skid_dst_reg;
        skid_rw_next    = skid_rw_reg;
        // A transfer seen by the consumer counts even when flushed.
        cnt_next        = cnt_reg + ((xfer && out_rw_reg) ? CNT_W'(1) : CNT_W'(0));

        if (Flush) begin
            out_valid_next  = 1'b0;
            skid_valid_next = 1'b0;
        end else if (SKID != 0) begin
            if (xfer && skid_valid_reg) begin
                // In_Ready is low while the skid is full, so no accept here.
                out_data_next   = skid_data_reg;
                out_dst_next    = skid_dst_reg;
                out_rw_next     = skid_rw_reg;
                skid_valid_next = 1'b0;
            end else if (xfer) begin
                if (accept) begin
                    out_data_next = in_data;
                    out_dst_next  = Dst_In;
                    out_rw_next   = in_rw;
                end else begin
                    out_valid_next = 1'b0;
                end
            end else if (accept) begin
                if (out_valid_reg) begin
                    skid_data_next  = in_data;
                    skid_dst_next   = Dst_In;
                    skid_rw_next    = in_rw;
                    skid_valid_next = 1'b1;
                end else begin
                    out_data_next  = in_data;
                    out_dst_next   = Dst_In;
                    out_rw_next    = in_rw;
                    out_valid_next = 1'b1;
                end
            end
        end else begin
            if (accept) begin
                out_data_next  = in_data;
                out_dst_next   = Dst_In;
                out_rw_next    = in_rw;
                out_valid_next = 1'b1;
            end else if (xfer) begin
                out_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_dst_reg    <= '0;
            out_rw_reg     <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_dst_reg   <= '0;
            skid_rw_reg    <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            out_dst_reg    <= out_dst_next;
            out_rw_reg     <= out_rw_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_dst_reg   <= skid_dst_next;
            skid_rw_reg    <= skid_rw_next;
            cnt_reg        <= cnt_next;
        end
    end

    assign Out_Valid    = out_valid_reg;
    assign Data_Out     = out_data_reg;
    assign Dst_Out      = out_dst_reg;
    assign RegWrite_Out = out_rw_reg;
    assign Fwd_Valid    = out_valid_reg && out_rw_reg;
    assign Fwd_Dst      = out_dst_reg;
    assign Fwd_Data     = out_data_reg;
    assign Commit_Cnt   = cnt_reg;

endmodule

// File: tb/tb_wb_stage_p.sv
// Self-checking bench for wb_stage_p (DATA_W=32, SKID=1, ZERO_REG=1, CNT_W=4).
// A queue of expected transactions models the two-entry stage.
module tb_wb_stage_p;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        In_Valid;
    logic        In_Ready;
    logic [31:0] Alu_In, Mem_In, Pc4_In;
    logic [1:0]  WBSel_In;
    logic        RegWrite_In;
    logic [4:0]  Dst_In;
    logic [1:0]  MemSize_In;
    logic        MemSigned_In;
    logic [1:0]  ByteOff_In;
    logic        Flush;
    logic        Out_Ready;
    logic        Out_Valid;
    logic [31:0] Data_Out;
    logic [4:0]  Dst_Out;
    logic        RegWrite_Out;
    logic        Fwd_Valid;
    logic [4:0]  Fwd_Dst;
    logic [31:0] Fwd_Data;
    logic [3:0]  Commit_Cnt;

    always #5 Clk = ~Clk;

    wb_stage_p #(
        .DATA_W(32), .REG_ADDR_W(5), .SKID(1), .ZERO_REG(1), .CNT_W(4)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Alu_In(Alu_In), .Mem_In(Mem_In), .Pc4_In(Pc4_In), .WBSel_In(WBSel_In),
        .RegWrite_In(RegWrite_In), .Dst_In(Dst_In), .MemSize_In(MemSize_In),
        .MemSigned_In(MemSigned_In), .ByteOff_In(ByteOff_In), .Flush(Flush),
        .Out_Ready(Out_Ready), .Out_Valid(Out_Valid), .Data_Out(Data_Out),
        .Dst_Out(Dst_Out), .RegWrite_Out(RegWrite_Out), .Fwd_Valid(Fwd_Valid),
        .Fwd_Dst(Fwd_Dst), .Fwd_Data(Fwd_Data), .Commit_Cnt(Commit_Cnt)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  dst;
        logic        rw;
    } rec_t;

    rec_t       q[$];
    logic [3:0] cnt_model;
    int         n_pass  = 0;
    int         n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference formatting from the architectural rules.
    function automatic rec_t ref_rec();
        rec_t        r;
        logic [31:0] v;
        int          sh;
        case (WBSel_In)
            2'd1: begin
                case (MemSize_In)
                    2'd0: begin
                        sh = 8 * int'(ByteOff_In);
                        v  = (Mem_In >> sh) & 32'hFF;
                        if (MemSigned_In && v[7]) v = v | 32'hFFFF_FF00;
                    end
                    2'd1: begin
                        sh = 16 * (int'(ByteOff_In) / 2);
                        v  = (Mem_In >> sh) & 32'hFFFF;
                        if (MemSigned_In && v[15]) v = v | 32'hFFFF_0000;
                    end
                    default: v = Mem_In;
                endcase
            end
            2'd2:    v = Pc4_In;
            default: v = Alu_In;
        endcase
        r.data = v;
        r.dst  = Dst_In;
        r.rw   = RegWrite_In && (Dst_In != 5'd0);
        return r;
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic go(input logic flush, input logic ordy, output bit acc);
        bit   exp_ir, exp_ov, xf;
        rec_t nr, head;
        Flush     = flush;
        Out_Ready = ordy;
        #1;
        exp_ir = (q.size() < 2);
        exp_ov = (q.size() > 0);
        check("in_ready",  In_Ready,   exp_ir);
        check("out_valid", Out_Valid,  exp_ov);
        check("commit_cnt", Commit_Cnt, cnt_model);
        if (exp_ov) begin
            head = q[0];
            check("data_out", Data_Out, head.data);
            check("dst_out",  Dst_Out,  head.dst);
            check("rw_out",   RegWrite_Out, head.rw);
            check("fwd_valid", Fwd_Valid, head.rw);
            check("fwd_data", Fwd_Data, head.data);
            check("fwd_dst",  Fwd_Dst,  head.dst);
        end
        acc = In_Valid && exp_ir;
        xf  = exp_ov && ordy;
        nr  = ref_rec();
        @(posedge Clk);
        if (xf) begin
            head = q.pop_front();
            if (head.rw) cnt_model = cnt_model + 4'd1;
            $display("retire dst=%0d data=%h rw=%0d", head.dst, head.data, head.rw);
        end
        if (flush) q.delete();
        else if (acc) q.push_back(nr);
        @(negedge Clk);
    endtask

    task automatic set_in(input logic v, input logic [1:0] sel, input logic [31:0] alu,
                          input logic [31:0] mem, input logic [1:0] sz, input logic sgn,
                          input logic [1:0] off, input logic rw, input logic [4:0] dst);
        In_Valid = v; WBSel_In = sel; Alu_In = alu; Mem_In = mem; Pc4_In = alu + 32'd4;
        MemSize_In = sz; MemSigned_In = sgn; ByteOff_In = off; RegWrite_In = rw; Dst_In = dst;
    endtask

    initial begin
        bit         acc;
        logic [3:0] cnt_before;
        Rst_n = 1'b0; Flush = 1'b0; Out_Ready = 1'b0;
        set_in(1'b0, 2'd0, 32'd0, 32'd0, 2'd0, 1'b0, 2'd0, 1'b0, 5'd0);
        q.delete();
        cnt_model = 4'd0;
        repeat (2) @(negedge Clk);
        check("rst_out_valid", Out_Valid, 1'b0);
        check("rst_in_ready", In_Ready, 1'b1);
        check("rst_data", Data_Out, 32'd0);
        check("rst_cnt", Commit_Cnt, 4'd0);
        Rst_n = 1'b1;

        // 17 writing transfers wrap a 4-bit counter to 1.
        for (int i = 0; i < 17; i++) begin
            set_in(1'b1, 2'd0, 32'h100 + i, 32'd0, 2'd0, 1'b0, 2'd0, 1'b1, 5'(1 + i % 31));
            go(1'b0, 1'b1, acc);
        end
        In_Valid = 1'b0;
        go(1'b0, 1'b1, acc);
        check("cnt_wrap", Commit_Cnt, 4'd1);

        // Load formatting.
        set_in(1'b1, 2'd1, 32'd0, 32'h80FF_7F01, 2'd0, 1'b1, 2'd2, 1'b0, 5'd3);
        go(1'b0, 1'b1, acc);
        check("ld_b_signed", Data_Out, 32'hFFFF_FFFF);
        set_in(1'b1, 2'd1, 32'd0, 32'h80FF_7F01, 2'd0, 1'b0, 2'd3, 1'b0, 5'd3);
        go(1'b0, 1'b1, acc);
        check("ld_b_unsigned", Data_Out, 32'h0000_0080);
        set_in(1'b1, 2'd1, 32'd0, 32'h8001_1234, 2'd1, 1'b1, 2'd2, 1'b0, 5'd3);
        go(1'b0, 1'b1, acc);
        check("ld_h_off2", Data_Out, 32'hFFFF_8001);
        set_in(1'b1, 2'd1, 32'd0, 32'h8001_1234, 2'd1, 1'b1, 2'd3, 1'b0, 5'd3);
        go(1'b0, 1'b1, acc);
        check("ld_h_off3", Data_Out, 32'hFFFF_8001);
        In_Valid = 1'b0;
        go(1'b0, 1'b1, acc);

        // Skid: three back-to-back with the consumer stalled for two cycles.
        set_in(1'b1, 2'd0, 32'hA, 32'd0, 2'd0, 1'b0, 2'd0, 1'b1, 5'd10);
        go(1'b0, 1'b0, acc);
        set_in(1'b1, 2'd0, 32'hB, 32'd0, 2'd0, 1'b0, 2'd0, 1'b1, 5'd11);
        go(1'b0, 1'b0, acc);
        check("skid_full_ready", In_Ready, 1'b0);
        set_in(1'b1, 2'd0, 32'hC, 32'd0, 2'd0, 1'b0, 2'd0, 1'b1, 5'd12);
        acc = 1'b0;
        for (int i = 0; i < 6 && !acc; i++) go(1'b0, 1'b1, acc);
        check("skid_third_accepted", acc, 1'b1);
        In_Valid = 1'b0;
        repeat (3) go(1'b0, 1'b1, acc);
        check("skid_drained", Out_Valid, 1'b0);

        // Zero-register write suppression.
        cnt_before = cnt_model;
        set_in(1'b1, 2'd0, 32'h1234, 32'd0, 2'd0, 1'b0, 2'd0, 1'b1, 5'd0);
        go(1'b0, 1'b0, acc);
        check("zero_valid", Out_Valid, 1'b1);
        check("zero_rw", RegWrite_Out, 1'b0);
        check("zero_data", Data_Out, 32'h1234);
        In_Valid = 1'b0;
        go(1'b0, 1'b1, acc);
        check("zero_cnt", Commit_Cnt, cnt_before);

        // Flush with output and skid full and a new input pending.
        cnt_before = cnt_model;
        set_in(1'b1, 2'd0, 32'h55, 32'd0, 2'd0, 1'b0, 2'd0, 1'b1, 5'd5);
        go(1'b0, 1'b0, acc);
        go(1'b0, 1'b0, acc);
        go(1'b1, 1'b0, acc);
        In_Valid = 1'b0;
        check("flush_valid", Out_Valid, 1'b0);
        check("flush_ready", In_Ready, 1'b1);
        check("flush_cnt", Commit_Cnt, cnt_before);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom % 10) < 7, 2'($urandom), $urandom, $urandom,
                   2'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 5'($urandom));
            go(($urandom % 16) == 0, 1'($urandom), acc);
        end

        // Asynchronous reset in the middle of a stall.
        set_in(1'b1, 2'd0, 32'h77, 32'd0, 2'd0, 1'b0, 2'd0, 1'b1, 5'd7);
        go(1'b0, 1'b0, acc);
        go(1'b0, 1'b0, acc);
        In_Valid = 1'b0;
        #2 Rst_n = 1'b0;
        #1;
        check("arst_valid", Out_Valid, 1'b0);
        check("arst_data", Data_Out, 32'd0);
        check("arst_dst", Dst_Out, 5'd0);
        check("arst_rw", RegWrite_Out, 1'b0);
        check("arst_cnt", Commit_Cnt, 4'd0);
        check("arst_ready", In_Ready, 1'b1);
        q.delete();
        cnt_model = 4'd0;
        @(negedge Clk);
        Rst_n = 1'b1;
        go(1'b0, 1'b1, acc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
